// File: rtl/multi_lane_pkg.sv
// Shared defaults, state encoding and latency helpers for multi_lane_const.
// Build macro MULTI_LANE_STAGGER_EN selects staggered per-lane latency in lane_lat().
package multi_lane_pkg;

    localparam int          DEF_LANES      = 2;
    localparam int          DEF_LANE_W     = 32;
    localparam int          DEF_LATENCY    = 3;
    localparam int unsigned DEF_LANE_CONST = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ml_state_e;

    // Sized so that the largest lane latency can never wrap the counter.
    function automatic int cnt_width(input int latency, input int lanes);
        return $clog2(latency + lanes) + 32'sd1;
    endfunction

    function automatic int lane_lat(input int latency, input int idx);
        bit stagger;
`ifdef MULTI_LANE_STAGGER_EN
        stagger = 1'b1;
`else
        stagger = 1'b0;
`endif
        return latency + (stagger ? idx : 32'sd0);
    endfunction

endpackage

// File: rtl/multi_lane_unit.sv
// One lane engine: latches its operand on load and raises lane_done
// exactly LAT cycles after the accepting edge; result is operand + constant.
module multi_lane_unit
    import multi_lane_pkg::*;
#(
    parameter int          LANE_W     = DEF_LANE_W,
    parameter int          CNT_W      = 4,
    parameter int          LAT        = DEF_LATENCY,
    parameter int unsigned LANE_CONST = DEF_LANE_CONST
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LANE_W-1:0] operand,
    output logic              lane_done,
    output logic [LANE_W-1:0] result
);

    localparam logic [LANE_W-1:0] CONST_V  = LANE_W'(LANE_CONST);
    localparam logic [CNT_W-1:0]  LOAD_CNT = CNT_W'(LAT - 32'sd1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

    logic [LANE_W-1:0] operand_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r;

    // cnt_r holds the cycles still to wait before the pulse cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            operand_r <= '0;
            cnt_r     <= '0;
            done_r    <= 1'b0;
        end else if (load) begin
            operand_r <= operand;
            cnt_r     <= LOAD_CNT;
            done_r    <= (LAT == 32'sd1);
        end else if (cnt_r != '0) begin
            cnt_r  <= cnt_r - CNT_ONE;
            done_r <= (cnt_r == CNT_ONE);
        end else begin
            done_r <= 1'b0;
        end
    end

    assign lane_done = done_r;
    assign result    = operand_r + CONST_V;

endmodule

// File: rtl/multi_lane_const.sv
// Multi-lane constant-add unit: LANES lane engines, per-lane capture buffers
// and a merged output. Build macro MULTI_LANE_STAGGER_EN staggers lane latency.
module multi_lane_const
    import multi_lane_pkg::*;
#(
    parameter int          LANES      = DEF_LANES,
    parameter int          LANE_W     = DEF_LANE_W,
    parameter int          LATENCY    = DEF_LATENCY,
    parameter int unsigned LANE_CONST = DEF_LANE_CONST
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic [LANES*LANE_W-1:0] inp,
    output logic                    busy,
    output logic [LANES-1:0]        lane_done,
    output logic                    done,
    output logic [LANES*LANE_W-1:0] out
);

    localparam int CNT_W = cnt_width(LATENCY, LANES);
    localparam int LAST  = LANES - 1;

    ml_state_e                 state_r;
    logic                      busy_s;
    logic                      accept_s;
    logic                      done_s;
    logic [LANES-1:0]          lane_done_s;
    logic [LANE_W-1:0]         result_s   [LANES];
    logic [LANE_W-1:0]         lane_buf_r [LANES];
    logic [LANES*LANE_W-1:0]   out_s;

    assign busy_s   = (state_r == ST_RUN);
    assign accept_s = start & ~busy_s;
    // Latencies are non-decreasing with lane index, so the last lane finishes last.
    assign done_s   = busy_s & lane_done_s[LAST];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        multi_lane_unit #(
            .LANE_W     (LANE_W),
            .CNT_W      (CNT_W),
            .LAT        (lane_lat(LATENCY, i)),
            .LANE_CONST (LANE_CONST)
        ) u_unit (
            .clock     (clock),
            .reset     (reset),
            .load      (accept_s),
            .operand   (inp[i*LANE_W +: LANE_W]),
            .lane_done (lane_done_s[i]),
            .result    (result_s[i])
        );
    end

    // Top-level operation state: idle until accepted, run until the done cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: if (accept_s)          state_r <= ST_RUN;
                ST_RUN:  if (lane_done_s[LAST]) state_r <= ST_IDLE;
                default:                        state_r <= ST_IDLE;
            endcase
        end
    end

    // Capture each lane result at the end of its completion cycle.
    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (reset) begin
                lane_buf_r[i] <= '0;
            end else if (lane_done_s[i]) begin
                lane_buf_r[i] <= result_s[i];
            end
        end
    end

    // Live result in a lane's completion cycle, buffered value otherwise.
    always_comb begin
        out_s = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_done_s[i]) begin
                out_s[i*LANE_W +: LANE_W] = result_s[i];
            end else begin
                out_s[i*LANE_W +: LANE_W] = lane_buf_r[i];
            end
        end
    end

    assign busy      = busy_s;
    assign lane_done = lane_done_s;
    assign done      = done_s;
    assign out       = out_s;

endmodule

// File: tb/tb_multi_lane_const.sv
// Scoreboard bench for multi_lane_const: a timing/arith reference model predicts
// per-cycle outputs and each operation's done cycle and merged result.
module tb_multi_lane_const;

    localparam int          LANES      = 2;
    localparam int          LANE_W     = 32;
    localparam int          LATENCY    = 3;
    localparam int unsigned LANE_CONST = 1;
    localparam int          W          = LANES * LANE_W;
`ifdef MULTI_LANE_STAGGER_EN
    localparam bit STAG = 1'b1;
`else
    localparam bit STAG = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     inp   = '0;
    logic             busy;
    logic [LANES-1:0] lane_done;
    logic             done;
    logic [W-1:0]     out;

    always #5 clock = ~clock;

    multi_lane_const #(
        .LANES      (LANES),
        .LANE_W     (LANE_W),
        .LATENCY    (LATENCY),
        .LANE_CONST (LANE_CONST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .inp       (inp),
        .busy      (busy),
        .lane_done (lane_done),
        .done      (done),
        .out       (out)
    );

    typedef struct {
        logic [W-1:0] exp_out;
        int           done_at;
    } op_t;

    op_t              sb_q[$];
    int               edge_cnt  = 0;
    int               next_free = 0;
    bit               checking  = 1'b0;
    int               n_cmp     = 0;
    int               n_fail    = 0;
    logic [LANE_W-1:0] field_m  [LANES];
    logic [LANE_W-1:0] pend_val [LANES];
    int                pend_at  [LANES];

    function automatic int lat_of(input int i);
        return LATENCY + (STAG ? i : 0);
    endfunction

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
        end
    endtask

    // Driver: sets inputs just after the falling edge and tells the model
    // what the next rising edge (index e) will do.
    task automatic step(input bit s, input bit r, input logic [W-1:0] d);
        int e;
        int lmax;
        logic [W-1:0] eo;
        @(negedge clock);
        #1;
        start = s;
        reset = r;
        inp   = d;
        e     = edge_cnt + 1;
        lmax  = lat_of(LANES - 1);
        if (r) begin
            sb_q.delete();
            for (int i = 0; i < LANES; i++) begin
                field_m[i] = '0;
                pend_at[i] = -1;
            end
            next_free = e + 1;
            checking  = 1'b1;
        end else if (s && checking && e >= next_free) begin
            for (int i = 0; i < LANES; i++) begin
                pend_val[i] = d[i*LANE_W +: LANE_W] + LANE_W'(LANE_CONST);
                pend_at[i]  = e + lat_of(i) - 1;
                eo[i*LANE_W +: LANE_W] = pend_val[i];
            end
            sb_q.push_back('{eo, e + lmax - 1});
            next_free = e + lmax + 1;
        end
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each done.
    always @(negedge clock) begin
        if (checking) begin
            int n;
            logic [LANES-1:0] exp_ld;
            logic [W-1:0] exp_out;
            op_t op;
            n = edge_cnt;
            exp_ld = '0;
            for (int i = 0; i < LANES; i++) begin
                if (pend_at[i] == n) begin
                    exp_ld[i]  = 1'b1;
                    field_m[i] = pend_val[i];
                    pend_at[i] = -1;
                end
                exp_out[i*LANE_W +: LANE_W] = field_m[i];
            end
            check("lane_done", 64'(lane_done), 64'(exp_ld));
            check("out", 64'(out), 64'(exp_out));
            check("busy", 64'(busy), 64'(n <= next_free - 2));
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("spurious_done", 64'(done), 64'd0);
                end else begin
                    op = sb_q.pop_front();
                    check("done_cycle", 64'(n), 64'(op.done_at));
                    check("done_out", 64'(out), 64'(op.exp_out));
                end
            end else if (sb_q.size() > 0 && sb_q[0].done_at < n) begin
                op = sb_q.pop_front();
                check("done_missing", 64'(done), 64'd1);
            end
        end
    end

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            if ($urandom_range(0, 3) == 0) d[i*LANE_W +: LANE_W] = '1;
            else                           d[i*LANE_W +: LANE_W] = LANE_W'($urandom());
        end
        return d;
    endfunction

    initial begin
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [W-1:0] w2;
        for (int i = 0; i < LANES; i++) begin
            field_m[i]  = '0;
            pend_val[i] = '0;
            pend_at[i]  = -1;
        end
        w0 = {32'h0000_0005, 32'hFFFF_FFFF};
        w1 = 64'h0000_0000_0000_1234;
        w2 = {32'h0000_0001, 32'h0000_0002};
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b1, '0);
        // Basic/wrap plus an ignored start while busy.
        step(1'b1, 1'b0, w0);
        step(1'b1, 1'b0, w1);
        repeat (5) step(1'b0, 1'b0, '0);
        // Reset two edges into an operation, then a fresh start.
        step(1'b1, 1'b0, rand_word());
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b1, 1'b0, w2);
        repeat (6) step(1'b0, 1'b0, '0);
        // Start held high: done-cycle start ignored, the next one accepted.
        repeat (14) step(1'b1, 1'b0, rand_word());
        step(1'b1, 1'b1, rand_word());
        repeat (3) step(1'b0, 1'b0, '0);
        repeat (3000) begin
            step(($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0), rand_word());
        end
        repeat (10) step(1'b0, 1'b0, '0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_lane_const.md
# multi_lane_const

Parametrised multi-lane, multi-cycle constant-add unit. Splits a wide operand into `LANES` independent lanes. Each lane computes `lane + LANE_CONST` over a fixed number of cycles. Results are merged into one wide output, with per-lane capture buffers so lanes that finish early are held until the last lane completes. It sits wherever a fixed-latency wide transaction is built from narrower multi-cycle lane engines, and is the generalised successor of the two-lane 64-bit wrapper.

## Interface
- `LANES`, default 2: number of lanes, ≥1.
- `LANE_W`, default 32: width of each lane in bits, ≥1.
- `LATENCY`, default 3: base lane latency in cycles, ≥1.
- `LANE_CONST`, default 1: constant added in every lane, truncated to `LANE_W`.
- `clock`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request. Accepted only when `busy`=0.
- `inp`, input, LANES*LANE_W: operand. Lane i is `inp[i*LANE_W +: LANE_W]`. Sampled only on an accepted start.
- `busy`, output, 1: an operation is in flight.
- `lane_done`, output, LANES: one-cycle pulse per lane on completion.
- `done`, output, 1: one-cycle pulse when all lanes of the operation have completed.
- `out`, output, LANES*LANE_W: merged result, same lane packing as `inp`.

## Operation
- Per-lane result is `(operand_i + LANE_CONST) mod 2^LANE_W`. Carries never cross lanes.
- Accept: `start`=1, `busy`=0 and `reset`=0 at edge T.
  - Each lane latches its operand slice.
  - Each lane loads its latency L_i.
  - `busy` rises in cycle T+1.
- While `busy`=1, `start` is ignored: operands are not re-latched and counters are not restarted.
- Lane i pulses `lane_done[i]` in exactly one cycle, T+L_i. In that same cycle the lane result is driven combinationally onto its `out` field and written into `lane_buf[i]` at the edge ending the cycle.
- In any cycle, `out` field i shows the lane's live result if `lane_done[i]`=1, otherwise it shows `lane_buf[i]`.
- `done` pulses in cycle T+L_max, where L_max is the largest L_i. It is gated by `busy`, so it never fires spuriously.
- `busy` stays 1 through the `done` cycle and falls in cycle T+L_max+1.
  - The earliest next accepted start is at the edge ending cycle T+L_max+1.
  - A start asserted in the `done` cycle is ignored.
- After `done`, `out` holds the final result unchanged. A field changes only when the same lane of a later operation completes.
- States, top level: IDLE → (accepted start) → RUN → (`done` cycle) → IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `lane_done`=0, all `lane_buf`=0, `out`=0. All lane counters are cleared and all lanes are inactive.
- Reset mid-operation aborts the operation:
  - No `lane_done` or `done` pulse from that operation.
  - `out` is 0 from the cycle after reset.
- Start asserted together with reset is ignored.
- Latency from accepted start to `done`:
  - `LATENCY` cycles without stagger.
  - `LATENCY+LANES-1` cycles with stagger.
- Counter width is `$clog2(LATENCY+LANES)+1` bits. No wrap is possible within an operation.

## Configuration
- `MULTI_LANE_STAGGER_EN` defined: L_i = `LATENCY`+i. Lane 0 finishes first, lane LANES-1 last; earlier lanes are served from `lane_buf`.
- `MULTI_LANE_STAGGER_EN` undefined: L_i = `LATENCY` for all lanes. All `lane_done` bits pulse together with `done`, and `out` equals the live results in that cycle.

## Structure
- Package `multi_lane_pkg` holds:
  - default parameter constants;
  - the counter-width function;
  - the lane-latency function `lane_lat(i)`, which contains the stagger ifdef.
- Sub-module `multi_lane_unit` implements one lane: operand register, down-counter, `done` pulse, result adder.
- The top level generates `LANES` instances, the buffers, the `out` mux, `busy`, and the `done` logic.

## Test plan
Bench configuration: LANES=2, LANE_W=32, LATENCY=3, LANE_CONST=1 unless stated.
- Basic and wrap, stagger off: start at T with `inp`=`{32'h0000_0005, 32'hFFFF_FFFF}` → `done` at T+3, `out`=`{32'h0000_0006, 32'h0000_0000}`, `busy` falls at T+4.
- Start while busy: second start at T+1 with `inp`=`64'h1234` → ignored. A single `done` at T+3 carries the first result.
- Stagger on, same stimulus:
  - `lane_done`=2'b01 at T+3 and 2'b10 at T+4, with `done` at T+4.
  - At T+4, `out[31:0]`=0 comes from the buffer.
  - At T+3, `out[31:0]` already shows 0.
- Reset at T+2 of an operation → no `lane_done` or `done`; `out`=0 and `busy`=0 from T+3. A start at T+5 with `inp`=`{32'h1, 32'h2}` → `done` at T+8 with `out`=`{32'h2, 32'h3}`.
- Back-to-back starts:
  - Start in the `done` cycle is ignored.
  - Start one cycle later is accepted.
  - `out` holds the previous result until that operation's lane completes.
- Edge config, LANES=4, LANE_W=8, LATENCY=1: `inp`=`32'hFF01_7F00` → `done` at T+1, `out`=`32'h0002_8001`.
